// File: rtl/nios2_system_interval_timer_v2.sv
// Avalon-MM interval timer: loadable down-counter with snapshot, one-shot/continuous modes and a level IRQ.
// Optional tick prescaler at address 6, built only when TIMER_PRESCALER_EN is defined.
module nios2_system_interval_timer_v2 #(
  parameter int unsigned COUNTER_WIDTH  = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h4E1,
  parameter bit          START_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int unsigned   CW           = COUNTER_WIDTH;
  localparam logic [CW-1:0] RESET_PERIOD = DEFAULT_PERIOD[CW-1:0];

  typedef enum logic [2:0] {
    A_STATUS   = 3'd0,
    A_CONTROL  = 3'd1,
    A_PERIOD_L = 3'd2,
    A_PERIOD_H = 3'd3,
    A_SNAP_L   = 3'd4,
    A_SNAP_H   = 3'd5,
    A_PRESCALE = 3'd6,
    A_RESERVED = 3'd7
  } addr_e;

  logic [CW-1:0] counter, period, snapshot, period_new;
  logic          run, cont, ito, to;
  logic          wr, wr_status, wr_control, wr_period, wr_snap, start_wr;
  logic          tick, expire;
  logic [31:0]   period_ext, snap_ext, period_wr_ext;
  logic [15:0]   rd_mux;

  assign wr         = chipselect & ~write_n;
  assign wr_status  = wr && address == A_STATUS;
  assign wr_control = wr && address == A_CONTROL;
  assign wr_period  = wr && (address == A_PERIOD_L || address == A_PERIOD_H);
  assign wr_snap    = wr && (address == A_SNAP_L || address == A_SNAP_H);
  assign start_wr   = wr_control & writedata[2];

  assign period_ext = 32'(period);
  assign snap_ext   = 32'(snapshot);

  // Bits above COUNTER_WIDTH fall away in the truncation, so narrow builds ignore them on write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    period_wr_ext = period_ext;
    if (address == A_PERIOD_L) period_wr_ext[15:0]  = writedata;
    if (address == A_PERIOD_H) period_wr_ext[31:16] = writedata;
  end
  assign period_new = period_wr_ext[CW-1:0];

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale, pre_cnt;
  logic        wr_prescale;

  assign wr_prescale = wr && address == A_PRESCALE;
  assign tick        = (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_prescale) prescale <= writedata;
      if (wr_prescale || wr_period || start_wr || tick) pre_cnt <= '0;
      else                                              pre_cnt <= pre_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign expire = tick && run && counter == '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      A_STATUS:   rd_mux = {14'b0, run, to};
      A_CONTROL:  rd_mux = {14'b0, cont, ito};
      A_PERIOD_L: rd_mux = period_ext[15:0];
      A_PERIOD_H: rd_mux = period_ext[31:16];
      A_SNAP_L:   rd_mux = snap_ext[15:0];
      A_SNAP_H:   rd_mux = snap_ext[31:16];
`ifdef TIMER_PRESCALER_EN
      A_PRESCALE: rd_mux = prescale;
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Later assignments override earlier ones: tick, then CONTROL, then PERIOD write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      counter  <= RESET_PERIOD;
      period   <= RESET_PERIOD;
      snapshot <= '0;
      run      <= START_ON_RESET;
      cont     <= START_ON_RESET;
      ito      <= 1'b0;
      to       <= 1'b0;
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
      if (wr_snap) snapshot <= counter;
      if (tick && run) counter <= expire ? period : counter - CW'(1);
      if (expire && !cont) run <= 1'b0;
      if (wr_control) begin
        cont <= writedata[1];
        ito  <= writedata[0];
        if (writedata[3])      run <= 1'b0;
        else if (writedata[2]) run <= 1'b1;
      end
      if (wr_period) begin
        period  <= period_new;
        counter <= period_new;
        run     <= 1'b0;
      end
      // A timeout in the same cycle as a STATUS write keeps TO set.
      if (expire)         to <= 1'b1;
      else if (wr_status) to <= 1'b0;
    end
  end

  assign irq = to & ito;

endmodule

// File: tb/tb_nios2_system_interval_timer_v2.sv
// Self-checking bench: register-map vector table, hand-written corner sequences and randomized runs
// compared against a closed-form model of the timer.
module tb_nios2_system_interval_timer_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata, readdata2;
  logic        irq, irq2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nios2_system_interval_timer_v2 #(
    .COUNTER_WIDTH (20),
    .DEFAULT_PERIOD(32'h4E1),
    .START_ON_RESET(1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  nios2_system_interval_timer_v2 #(
    .COUNTER_WIDTH (12),
    .DEFAULT_PERIOD(32'hABCD),
    .START_ON_RESET(1'b1)
  ) dut_narrow (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata2),
    .irq       (irq2)
  );

  typedef struct {
    logic        cs;
    logic        we;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cs, input logic we, input logic [2:0] a, input logic [15:0] d);
    chipselect = cs;
    write_n    = ~we;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(1'b0, 1'b0, a, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int n);
    n = 0;
    while (!irq && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic add_vec(input logic cs, input logic we, input logic [2:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd);
    vec_t v;
    v = '{cs: cs, we: we, a: a, d: d, exp_rd: exp_rd, exp_irq: 1'b0};
    vecs.push_back(v);
  endtask

  // State after k ticks since START from a freshly loaded counter: one timeout per p+1 ticks.
  function automatic void model(input int unsigned p, input bit c, input int unsigned k,
                                output int unsigned cnt, output bit t, output bit r);
    if (c) begin
      cnt = p - (k % (p + 1));
      t   = (k >= p + 1);
      r   = 1'b1;
    end else if (k <= p) begin
      cnt = p - k;
      t   = 1'b0;
      r   = 1'b1;
    end else begin
      cnt = p;
      t   = 1'b1;
      r   = 1'b0;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int unsigned p, k, exp_cnt;
    bit          c, i, exp_to, exp_run, pt, pr;
    int unsigned pc;
    logic [15:0] ctrl;

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 16'h0;
    step();
    step();
    reset = 1'b0;
    check("reset_readdata", readdata, 0);
    check("reset_irq", irq, 0);

    // Narrow build, start-on-reset: running, truncated default period, high halves read 0.
    rd(3'd0); check("narrow_status", readdata2, 16'h0002);
    rd(3'd1); check("narrow_control", readdata2, 16'h0002);
    rd(3'd2); check("narrow_period_l", readdata2, 16'h0BCD);
    rd(3'd3); check("narrow_period_h", readdata2, 16'h0000);
    wr(3'd3, 16'hFFFF);
    rd(3'd3); check("narrow_period_h_wr", readdata2, 16'h0000);
    wr(3'd2, 16'hFFFF);
    rd(3'd2); check("narrow_period_l_wr", readdata2, 16'h0FFF);
    rd(3'd0); check("narrow_period_stops", readdata2, 16'h0000);
    wr(3'd4, 16'h0);
    rd(3'd5); check("narrow_snap_h", readdata2, 16'h0000);

    // Register map with the timer stopped; readdata shows the pre-edge value of the addressed register.
    do_reset();
    add_vec(0, 0, 3'd2, 16'h0000, 16'h04E1);
    add_vec(0, 0, 3'd3, 16'h0000, 16'h0000);
    add_vec(0, 0, 3'd1, 16'h0000, 16'h0000);
    add_vec(0, 0, 3'd0, 16'h0000, 16'h0000);
    add_vec(0, 0, 3'd7, 16'h0000, 16'h0000);
    add_vec(0, 0, 3'd6, 16'h0000, 16'h0000);
    add_vec(1, 1, 3'd6, 16'hFFFF, 16'h0000);
    add_vec(0, 0, 3'd6, 16'h0000, 16'h0000);
    add_vec(1, 1, 3'd1, 16'h0003, 16'h0000);
    add_vec(0, 0, 3'd1, 16'h0000, 16'h0003);
    add_vec(1, 1, 3'd1, 16'h000F, 16'h0003);
    add_vec(0, 0, 3'd1, 16'h0000, 16'h0003);
    add_vec(0, 0, 3'd0, 16'h0000, 16'h0000);
    add_vec(1, 1, 3'd2, 16'hBEEF, 16'h04E1);
    add_vec(1, 1, 3'd3, 16'hFFFF, 16'h0000);
    add_vec(0, 0, 3'd3, 16'h0000, 16'h000F);
    add_vec(0, 0, 3'd2, 16'h0000, 16'hBEEF);
    add_vec(0, 1, 3'd2, 16'h1111, 16'hBEEF);
    add_vec(0, 0, 3'd2, 16'h0000, 16'hBEEF);
    add_vec(1, 1, 3'd4, 16'h0000, 16'h0000);
    add_vec(0, 0, 3'd4, 16'h0000, 16'hBEEF);
    add_vec(0, 0, 3'd5, 16'h0000, 16'h000F);
    add_vec(1, 1, 3'd7, 16'h1234, 16'h0000);
    add_vec(0, 0, 3'd7, 16'h0000, 16'h0000);
    add_vec(1, 1, 3'd0, 16'h0000, 16'h0000);
    foreach (vecs[j]) begin
      bus(vecs[j].cs, vecs[j].we, vecs[j].a, vecs[j].d);
      check($sformatf("vec%0d_readdata", j), readdata, vecs[j].exp_rd);
      check($sformatf("vec%0d_irq", j), irq, vecs[j].exp_irq);
    end

    // Continuous, PERIOD=4: a timeout every 5 clocks, RUN stays set.
    do_reset();
    wr(3'd2, 16'd4); wr(3'd3, 16'd0); wr(3'd1, 16'h0007);
    wait_irq(20, n);
    check("cont_first_to", n, 5);
    for (int r = 0; r < 3; r++) begin
      wr(3'd0, 16'h0);
      wait_irq(20, n);
      check($sformatf("cont_gap%0d", r), n + 1, 5);
    end
    rd(3'd0); check("cont_run", readdata[1], 1);

    // One-shot, PERIOD=3 with ITO: 4 ticks, then stopped and reloaded.
    do_reset();
    wr(3'd2, 16'd3); wr(3'd3, 16'd0); wr(3'd1, 16'h0005);
    wait_irq(20, n);
    check("oneshot_ticks", n, 4);
    check("oneshot_irq", irq, 1);
    rd(3'd0); check("oneshot_status", readdata, 16'h0001);
    wr(3'd4, 16'h0);
    rd(3'd4); check("oneshot_counter", readdata, 16'd3);
    wr(3'd0, 16'h0);
    check("oneshot_irq_clear", irq, 0);

    // STATUS write on the expiring edge: the timeout wins.
    do_reset();
    wr(3'd2, 16'd4); wr(3'd3, 16'd0); wr(3'd1, 16'h0007);
    repeat (4) step();
    wr(3'd0, 16'h0);
    check("status_race_irq", irq, 1);
    wr(3'd1, 16'h000C);
    rd(3'd0); check("stop_wins_status", readdata, 16'h0001);

    // 20-bit period, snapshot at counter 0x12300.
    do_reset();
    wr(3'd2, 16'h2345); wr(3'd3, 16'h0001); wr(3'd1, 16'h0004);
    repeat (69) step();
    wr(3'd4, 16'h0);
    rd(3'd4); check("snap_l_20bit", readdata, 16'h2300);
    rd(3'd5); check("snap_h_20bit", readdata, 16'h0001);
    rd(3'd3); check("period_h_20bit", readdata, 16'h0001);

    // PERIOD=0 continuous: timeout every tick, counter stays 0.
    do_reset();
    wr(3'd2, 16'd0); wr(3'd3, 16'd0); wr(3'd1, 16'h0007);
    step();
    check("p0_irq", irq, 1);
    wr(3'd0, 16'h0);
    check("p0_irq_after_clear", irq, 1);
    wr(3'd4, 16'h0);
    rd(3'd4); check("p0_counter", readdata, 16'h0000);

    // Reset mid-count with TO and irq set.
    do_reset();
    wr(3'd2, 16'd2); wr(3'd3, 16'd0); wr(3'd1, 16'h0007);
    wait_irq(20, n);
    check("pre_reset_irq", irq, 1);
    address = 3'd2;
    do_reset();
    check("post_reset_irq", irq, 0);
    check("post_reset_readdata", readdata, 16'h0000);
    rd(3'd0); check("post_reset_status", readdata, 16'h0000);
    rd(3'd2); check("post_reset_period", readdata, 16'h04E1);
    wr(3'd4, 16'h0);
    rd(3'd4); check("post_reset_counter", readdata, 16'h04E1);

    // Randomized runs against the closed-form model.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20'hFFFFF) : $urandom_range(0, 40);
      c = 1'($urandom_range(0, 1));
      i = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 100);
      ctrl = 16'h0004 | {14'b0, c, i};
      wr(3'd1, 16'h0008);
      wr(3'd0, 16'h0);
      wr(3'd2, p[15:0]);
      wr(3'd3, {12'b0, p[19:16]});
      wr(3'd1, ctrl);
      address = 3'd0;
      for (int s = 0; s < int'(k); s++) step();
      model(p, c, k, exp_cnt, exp_to, exp_run);
      check($sformatf("rand%0d_irq", t), irq, exp_to & i);
      if (k >= 1) begin
        model(p, c, k - 1, pc, pt, pr);
        check($sformatf("rand%0d_status", t), readdata, {14'b0, pr, pt});
      end
      wr(3'd4, 16'h0);
      rd(3'd4); check($sformatf("rand%0d_snap_l", t), readdata, exp_cnt[15:0]);
      rd(3'd5); check($sformatf("rand%0d_snap_h", t), readdata, {12'b0, exp_cnt[19:16]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
